gat_load_ctrl: RTL

GAT_LOAD_CTRL -- requirements
Module: gat_load_ctrl

---
 rtl/gat_load_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/gat_load_ctrl.sv
// gat_load_ctrl: streams host words into four BRAMs in a fixed order
// (H data, node info, weights, subgraph), then waits for the accelerator's
// gat_ready level and signals completion with a one-cycle done pulse.
//
// Optional feature: define GAT_LOAD_CTRL_TIMEOUT_EN to add a watchdog in
// WAIT_GAT that raises timeout and finishes after TIMEOUT_CYCLES clocks.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      launches a sequence (honoured in IDLE only)
//   cnt_*                      per-BRAM word counts, latched on start
//   s_data/s_valid/s_ready     host stream
//   bram_din/bram_addra/bram_wea  shared BRAM write port (byte address)
//   *_bram_ena                 per-BRAM enables, at most one high
//   *_load_done                per-phase completion levels
//   gat_ready                  accelerator compute-complete level
//   busy, done, timeout        sequence status
module gat_load_ctrl #(
  parameter int unsigned TOP_WIDTH      = 32,
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cnt_h_data,
  input  logic [ADDR_W-1:0]    cnt_node_info,
  input  logic [ADDR_W-1:0]    cnt_wgt,
  input  logic [ADDR_W-1:0]    cnt_subgraph,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [ADDR_W+1:0]    bram_addra,
  output logic                 h_data_bram_ena,
  output logic                 h_node_info_bram_ena,
  output logic                 wgt_bram_ena,
  output logic                 subgraph_bram_ena,
  output logic                 bram_wea,
  output logic                 h_data_bram_load_done,
  output logic                 h_node_info_bram_load_done,
  output logic                 wgt_bram_load_done,
  input  logic                 gat_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_H, S_LD_NI, S_LD_WGT, S_LD_SG, S_WAIT_GAT, S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0][ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [3:0]               en_q, en_d;
  logic [2:0]               ld_done_q, ld_done_d;
  logic [TOP_WIDTH-1:0]     din_d;
  logic [ADDR_W+1:0]        addr_d;
  logic                     wea_d, s_ready_d, busy_d, done_d, timeout_d;
  logic [1:0]               ph;
  logic [3:0]               ph_oh;
  logic [ADDR_W-1:0]        cur_cnt;

`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Load phase that follows a given load state
  function automatic state_t phase_next(input state_t s);
    case (s)
      S_LD_H:   return S_LD_NI;
      S_LD_NI:  return S_LD_WGT;
      S_LD_WGT: return S_LD_SG;
      default:  return S_WAIT_GAT;
    endcase
  endfunction

  // Current phase index, its one-hot BRAM select and its latched count
  always_comb begin
    ph = 2'd0;
    case (state_q)
      S_LD_NI:  ph = 2'd1;
      S_LD_WGT: ph = 2'd2;
      S_LD_SG:  ph = 2'd3;
      default:  ph = 2'd0;
    endcase
    ph_oh   = 4'b0001 << ph;
    cur_cnt = cnt_q[ph];
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    din_d     = bram_din;
    addr_d    = bram_addra;
    en_d      = 4'b0000;
    wea_d     = 1'b0;
    ld_done_d = ld_done_q;
    s_ready_d = 1'b0;
`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
    timeout_d = timeout;
    wd_d      = '0;
`else
    timeout_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = {cnt_subgraph, cnt_wgt, cnt_node_info, cnt_h_data};
          idx_d     = '0;
          ld_done_d = 3'b000;
          timeout_d = 1'b0;
          state_d   = S_LD_H;
        end
      end
      S_LD_H, S_LD_NI, S_LD_WGT, S_LD_SG: begin
        if (cur_cnt == '0) begin
          // Empty phase: s_ready was held low here, just mark it complete
          ld_done_d = ld_done_q | ph_oh[2:0];
          state_d   = phase_next(state_q);
        end else if (s_valid && s_ready) begin
          din_d  = s_data;
          addr_d = {idx_q, 2'b00};
          en_d   = ph_oh;
          wea_d  = 1'b1;
          // idx+1 never exceeds the count, so no wrap at the top index
          if (idx_q + ADDR_W'(1) == cur_cnt) begin
            idx_d     = '0;
            ld_done_d = ld_done_q | ph_oh[2:0];
            state_d   = phase_next(state_q);
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_WAIT_GAT: begin
        if (gat_ready) begin
          state_d = S_FIN;
        end
`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ready is registered, so it is decoded from the state being entered
    case (state_d)
      S_LD_H:   s_ready_d = |cnt_d[0];
      S_LD_NI:  s_ready_d = |cnt_d[1];
      S_LD_WGT: s_ready_d = |cnt_d[2];
      S_LD_SG:  s_ready_d = |cnt_d[3];
      default:  s_ready_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      en_q       <= 4'b0000;
      ld_done_q  <= 3'b000;
      bram_din   <= '0;
      bram_addra <= '0;
      bram_wea   <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      ld_done_q  <= ld_done_d;
      bram_din   <= din_d;
      bram_addra <= addr_d;
      bram_wea   <= wea_d;
      s_ready    <= s_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign h_data_bram_ena            = en_q[0];
  assign h_node_info_bram_ena       = en_q[1];
  assign wgt_bram_ena               = en_q[2];
  assign subgraph_bram_ena          = en_q[3];
  assign h_data_bram_load_done      = ld_done_q[0];
  assign h_node_info_bram_load_done = ld_done_q[1];
  assign wgt_bram_load_done         = ld_done_q[2];

endmodule
